// File: rtl/mole_pkg.sv
// Shared definitions for the mole spawner and the whack scorer:
// hole codes, index-to-code mapping, LFSR geometry and position pick.
package mole_pkg;

  localparam logic [2:0] POS_NONE = 3'b000;
  localparam logic [2:0] POS_W    = 3'b001;
  localparam logic [2:0] POS_A    = 3'b010;
  localparam logic [2:0] POS_S    = 3'b011;
  localparam logic [2:0] POS_D    = 3'b100;
  localparam logic [2:0] POS_X    = 3'b101;

  localparam logic [2:0] HOLE_COUNT = 3'd5;

  localparam int               LFSR_W            = 16;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_UP  = 1'b1
  } mole_state_t;

  // Hole index (0=A,1=W,2=S,3=D,4=X) to the code seen by the scorer
  function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return POS_A;
      3'd1:    return POS_W;
      3'd2:    return POS_S;
      3'd3:    return POS_D;
      3'd4:    return POS_X;
      default: return POS_NONE;
    endcase
  endfunction

  // Fold a 3-bit random value onto 5 holes and never repeat the last hole
  function automatic logic [2:0] pick_idx(input logic [2:0] v, input logic [2:0] prev_idx);
    logic [2:0] idx;
    idx = (v < HOLE_COUNT) ? v : (v - HOLE_COUNT);
    if (idx == prev_idx) begin
      idx = (idx == (HOLE_COUNT - 3'd1)) ? 3'd0 : (idx + 3'd1);
    end else begin
      idx = idx;
    end
    return idx;
  endfunction

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR with enable, synchronous seed load and a
// parallel output of configurable width (low bits of the state).
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED_DEFAULT,
  parameter int                OUT_W = LFSR_W
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [LFSR_W-1:0] state_r;

  // Load has priority; otherwise shift left with XOR feedback when enabled
  always_ff @(posedge clk) begin
    if (load) begin
      state_r <= SEED;
    end else if (en) begin
      state_r <= {state_r[LFSR_W-2:0], lfsr_feedback(state_r)};
    end else begin
      state_r <= state_r;
    end
  end

  assign q = state_r[OUT_W-1:0];

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: alternates a fixed gap with a score-dependent visible
// window, picks non-repeating holes from an LFSR, withdraws the mole on a
// matching whack and counts escapes. Pause freezes everything and blanks
// the output while keeping the hidden mole and its remaining window.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int unsigned       UP_CYCLES  = 32'd100_000_000,
  parameter int unsigned       UP_STEP    = 32'd5_000_000,
  parameter int unsigned       MIN_UP     = 32'd20_000_000,
  parameter int unsigned       GAP_CYCLES = 32'd25_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       key_esc,
  input  logic       key_space,
  input  logic       A,
  input  logic       W,
  input  logic       X,
  input  logic       D,
  input  logic       S,
  input  logic [3:0] score,
  output logic [2:0] mole_pos,
  output logic       mole_hit,
  output logic       mole_miss,
  output logic [3:0] miss_cnt
);

  mole_state_t state_r, state_s;
  logic [31:0] gap_cnt_r, gap_cnt_s;
  logic [31:0] up_cnt_r, up_cnt_s;
  logic [2:0]  code_r, code_s;
  logic [2:0]  prev_idx_r, prev_idx_s;
  logic [2:0]  pos_r, pos_s;
  logic        hit_r, hit_s;
  logic        miss_r, miss_s;
  logic [3:0]  miss_cnt_r, miss_cnt_s;

  logic [2:0]  lfsr_low_s;
  logic [2:0]  pick_s;
  logic [31:0] step_total_s;
  logic [31:0] window_s;
  logic        button_s;

  mole_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (3)
  ) u_lfsr (
    .clk  (clk),
    .load (key_esc),
    .en   (!key_space),
    .q    (lfsr_low_s)
  );

  assign pick_s = pick_idx(lfsr_low_s, prev_idx_r);

  // Window length for a mole entering now, floored at MIN_UP
  always_comb begin
    step_total_s = 32'(score) * UP_STEP;
    if (step_total_s >= (UP_CYCLES - MIN_UP)) begin
      window_s = MIN_UP;
    end else begin
      window_s = UP_CYCLES - step_total_s;
    end
  end

  // Level of the button that matches the hidden mole's hole
  always_comb begin
    case (code_r)
      POS_A:   button_s = A;
      POS_W:   button_s = W;
      POS_S:   button_s = S;
      POS_D:   button_s = D;
      POS_X:   button_s = X;
      default: button_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic; pause holds all state and blanks mole_pos
  always_comb begin
    state_s    = state_r;
    gap_cnt_s  = gap_cnt_r;
    up_cnt_s   = up_cnt_r;
    code_s     = code_r;
    prev_idx_s = prev_idx_r;
    pos_s      = POS_NONE;
    hit_s      = 1'b0;
    miss_s     = 1'b0;
    miss_cnt_s = miss_cnt_r;
    if (key_space) begin
      pos_s = POS_NONE;
    end else begin
      case (state_r)
        ST_GAP: begin
          if (gap_cnt_r <= 32'd1) begin
            state_s    = ST_UP;
            up_cnt_s   = window_s;
            code_s     = idx_to_code(pick_s);
            prev_idx_s = pick_s;
            pos_s      = idx_to_code(pick_s);
          end else begin
            gap_cnt_s = gap_cnt_r - 32'd1;
          end
        end
        ST_UP: begin
          if (button_s) begin
            // A hit beats an expiring window
            hit_s     = 1'b1;
            state_s   = ST_GAP;
            gap_cnt_s = GAP_CYCLES;
          end else if (up_cnt_r <= 32'd1) begin
            miss_s     = 1'b1;
            miss_cnt_s = (miss_cnt_r == 4'd15) ? 4'd15 : (miss_cnt_r + 4'd1);
            state_s    = ST_GAP;
            gap_cnt_s  = GAP_CYCLES;
          end else begin
            up_cnt_s = up_cnt_r - 32'd1;
            pos_s    = code_r;
          end
        end
        default: begin
          state_s   = ST_GAP;
          gap_cnt_s = GAP_CYCLES;
        end
      endcase
    end
  end

  // State and registered outputs; key_esc overrides everything
  always_ff @(posedge clk) begin
    if (key_esc) begin
      state_r    <= ST_GAP;
      gap_cnt_r  <= GAP_CYCLES;
      up_cnt_r   <= 32'd0;
      code_r     <= POS_NONE;
      prev_idx_r <= 3'd0;
      pos_r      <= POS_NONE;
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      miss_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      gap_cnt_r  <= gap_cnt_s;
      up_cnt_r   <= up_cnt_s;
      code_r     <= code_s;
      prev_idx_r <= prev_idx_s;
      pos_r      <= pos_s;
      hit_r      <= hit_s;
      miss_r     <= miss_s;
      miss_cnt_r <= miss_cnt_s;
    end
  end

  assign mole_pos  = pos_r;
  assign mole_hit  = hit_r;
  assign mole_miss = miss_r;
  assign miss_cnt  = miss_cnt_r;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner with small timing parameters.
// A cycle-level behavioural model predicts every output; directed
// sequences add hand-computed expectations.
module tb_mole_spawner;

  localparam int UPC  = 20;
  localparam int STEP = 2;
  localparam int MINU = 4;
  localparam int GAPC = 5;
  localparam int LIM  = 2000;

  logic       clk = 1'b0;
  logic       key_esc, key_space, A, W, X, D, S;
  logic [3:0] score;
  logic [2:0] mole_pos;
  logic       mole_hit, mole_miss;
  logic [3:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mole_spawner #(
    .UP_CYCLES  (32'd20),
    .UP_STEP    (32'd2),
    .MIN_UP     (32'd4),
    .GAP_CYCLES (32'd5),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk       (clk),
    .key_esc   (key_esc),
    .key_space (key_space),
    .A         (A),
    .W         (W),
    .X         (X),
    .D         (D),
    .S         (S),
    .score     (score),
    .mole_pos  (mole_pos),
    .mole_hit  (mole_hit),
    .mole_miss (mole_miss),
    .miss_cnt  (miss_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL %s timed out waiting t=%0t", nm, $time);
  endtask

  // ---------------- behavioural model ----------------
  int code_of [5] = '{2, 1, 3, 4, 5};   // index 0..4 = A,W,S,D,X
  int m_phase, m_left, m_prev, m_cnt, m_lfsr;
  logic [2:0] exp_pos;
  logic       exp_hit, exp_miss;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 32'hFFFF;
  endfunction

  // Model update on each rising edge from the inputs applied for that edge
  always @(posedge clk) begin : model
    int ph, left, prev, cnt, lf, cur, idx, w;
    logic [4:0] btns;
    logic [2:0] p;
    logic h, m;
    ph = m_phase; left = m_left; prev = m_prev; cnt = m_cnt; lf = m_lfsr;
    btns = {X, D, S, W, A};
    p = 3'd0; h = 1'b0; m = 1'b0;
    if (key_esc) begin
      ph = 0; left = GAPC; lf = 32'hACE1; prev = 0; cnt = 0;
    end else if (!key_space) begin
      cur = lf;
      lf  = lfsr_next(lf);
      if (ph == 0) begin
        left = left - 1;
        if (left == 0) begin
          idx = (cur & 7) % 5;
          if (idx == prev) idx = (idx + 1) % 5;
          prev = idx;
          ph   = 1;
          w    = UPC - int'(score) * STEP;
          if (w < MINU) w = MINU;
          left = w;
          p    = 3'(code_of[idx]);
        end
      end else if (btns[prev]) begin
        h = 1'b1; ph = 0; left = GAPC;
      end else begin
        left = left - 1;
        if (left == 0) begin
          m = 1'b1;
          if (cnt < 15) cnt = cnt + 1;
          ph = 0; left = GAPC;
        end else begin
          p = 3'(code_of[prev]);
        end
      end
    end
    m_phase <= ph; m_left <= left; m_prev <= prev; m_cnt <= cnt; m_lfsr <= lf;
    exp_pos <= p; exp_hit <= h; exp_miss <= m;
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mole_pos",  32'(mole_pos),  32'(exp_pos));
      chk("mole_hit",  32'(mole_hit),  32'(exp_hit));
      chk("mole_miss", 32'(mole_miss), 32'(exp_miss));
      chk("miss_cnt",  32'(miss_cnt),  32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_rise(input string nm);
    int n;
    n = 0;
    while (mole_pos != 3'd0 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout({nm, "_fall"});
    n = 0;
    while (mole_pos == 3'd0 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout({nm, "_rise"});
  endtask

  task automatic measure(input int req, input string nm);
    int n;
    wait_rise(nm);
    n = 0;
    while (mole_pos != 3'd0 && n < LIM) begin @(negedge clk); n++; end
    chk(nm, n, req);
    chk({nm, "_miss"}, 32'(mole_miss), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hits, dark, n;
    logic [2:0] code, last;
    logic [7:0] seen;
    key_esc = 1'b1; key_space = 1'b0; score = 4'd0;
    {A, W, X, D, S} = 5'b00000;

    // 1. reset for two edges, then first mole after exactly five clocks
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pos", 32'(mole_pos), 32'd0);
    chk("rst_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_pulses", 32'({mole_hit, mole_miss}), 32'd0);
    key_esc = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) chk("gap_pos", 32'(mole_pos), 32'd0);
      else       chk("first_mole", 32'(mole_pos), 32'h1);   // seed 0xACE1 -> W
    end

    // 2. whack the first mole (W)
    W = 1'b1;
    @(negedge clk);
    chk("hit_pulse", 32'(mole_hit), 32'd1);
    chk("hit_pos", 32'(mole_pos), 32'd0);
    W = 1'b0;
    @(negedge clk);
    chk("hit_once", 32'(mole_hit), 32'd0);

    // 2b. A mole, A held for several cycles -> exactly one hit
    n = 0;
    while (mole_pos != 3'b010 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout("wait_A");
    A = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); hits += int'(mole_hit); end
    A = 1'b0;
    chk("a_hit_count", hits, 1);

    // 3. window timing and miss counter saturation
    key_esc = 1'b1; @(negedge clk); key_esc = 1'b0;
    measure(20, "win_s0");
    chk("miss_cnt_1", 32'(miss_cnt), 32'd1);
    for (int i = 0; i < 19; i++) measure(20, "win_s0_rep");
    chk("miss_sat", 32'(miss_cnt), 32'd15);

    // 4. score-dependent window
    score = 4'd15; measure(4, "win_s15");
    score = 4'd3;  measure(14, "win_s3");
    score = 4'd0;

    // 5. pause at window cycle 6 for 10 cycles with every button held
    wait_rise("pause");
    code = mole_pos;
    repeat (5) @(negedge clk);
    chk("pre_pause_code", 32'(mole_pos), 32'(code));
    key_space = 1'b1; {A, W, X, D, S} = 5'b11111;
    dark = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mole_pos == 3'd0 && !mole_hit) dark++;
    end
    chk("pause_dark", dark, 10);
    key_space = 1'b0; {A, W, X, D, S} = 5'b00000;
    @(negedge clk);
    n = 0;
    while (mole_pos == code && n < LIM) begin n++; @(negedge clk); end
    chk("pause_resume", n, 14);
    chk("pause_miss", 32'(mole_miss), 32'd1);

    // reset while a mole is up: no pulse, counter cleared
    wait_rise("rst_up");
    @(negedge clk);
    key_esc = 1'b1; @(negedge clk); key_esc = 1'b0;
    chk("rst_up_pos", 32'(mole_pos), 32'd0);
    chk("rst_up_pulses", 32'({mole_hit, mole_miss}), 32'd0);
    chk("rst_up_cnt", 32'(miss_cnt), 32'd0);

    // 6. 200 consecutive misses
    seen = 8'd0; last = 3'd0;
    for (int i = 0; i < 200; i++) begin
      wait_rise("seq");
      code = mole_pos;
      chk("code_legal", 32'(code >= 3'd1 && code <= 3'd5), 32'd1);
      if (i > 0) chk("adjacent_differ", 32'(code != last), 32'd1);
      seen[code] = 1'b1;
      last = code;
    end
    chk("all_codes", 32'(seen[5:1]), 32'h1F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
